// File: rtl/encoder_level_if.sv
// Encoder-side bundle: raw quadrature channels in, level/step/dir/err out.
// Valid/ready note: there is no backpressure; step or err high for one cycle marks one event.
interface encoder_level_if #(
    parameter int LEVEL_WIDTH = 8
) ();
    logic                   enc_a;
    logic                   enc_b;
    logic [LEVEL_WIDTH-1:0] level;
    logic                   step;
    logic                   dir;
    logic                   err;

    modport master (
        output enc_a,
        output enc_b,
        input  level,
        input  step,
        input  dir,
        input  err
    );

    modport slave (
        input  enc_a,
        input  enc_b,
        output level,
        output step,
        output dir,
        output err
    );
endinterface

// File: rtl/encoder_level.sv
// Quadrature encoder to level converter: sync, debounce, x4 Gray decode,
// saturating or wrapping up/down step of a registered level.
module encoder_level #(
    parameter int LEVEL_WIDTH     = 8,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int STEP            = 1,
    parameter bit WRAP            = 1'b0,
    parameter int RESET_LEVEL     = 0
) (
    input  logic           clk,
    input  logic           reset,
    encoder_level_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]          CNT_LAST  = CW'(DEBOUNCE_CYCLES);
    localparam logic [LEVEL_WIDTH:0]   STEP_EXT  = (LEVEL_WIDTH + 1)'(STEP);
    localparam logic [LEVEL_WIDTH-1:0] LEVEL_RST = LEVEL_WIDTH'(RESET_LEVEL);

    // Bit 1 carries channel A, bit 0 channel B throughout.
    logic [1:0]             w_raw;
    logic [1:0]             r_sync1;
    logic [1:0]             r_sync2;
    logic [1:0]             r_stable;
    logic [1:0]             r_prev;
    logic [CW-1:0]          r_cnt [2];
    logic [LEVEL_WIDTH-1:0] r_level;
    logic                   r_step;
    logic                   r_dir;
    logic                   r_err;

    logic                   w_up;
    logic                   w_down;
    logic                   w_both;
    logic [LEVEL_WIDTH:0]   w_sum;
    logic [LEVEL_WIDTH:0]   w_diff;
    logic [LEVEL_WIDTH-1:0] w_up_level;
    logic [LEVEL_WIDTH-1:0] w_down_level;

    assign w_raw = {bus.enc_a, bus.enc_b};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            r_prev   <= '0;
            for (int i = 0; i < 2; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_prev  <= r_stable;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if ((r_cnt[i] + CW'(1)) == CNT_LAST) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        w_up   = 1'b0;
        w_down = 1'b0;
        case ({r_prev, r_stable})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_up   = 1'b1;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_down = 1'b1;
            default: ;
        endcase
    end

    assign w_both = &(r_prev ^ r_stable);

    // One extra bit exposes the carry on overflow and the borrow on underflow.
    assign w_sum  = {1'b0, r_level} + STEP_EXT;
    assign w_diff = {1'b0, r_level} - STEP_EXT;

    always_comb begin
        w_up_level   = w_sum[LEVEL_WIDTH-1:0];
        w_down_level = w_diff[LEVEL_WIDTH-1:0];
        if (!WRAP && w_sum[LEVEL_WIDTH]) begin
            w_up_level = '1;
        end
        if (!WRAP && w_diff[LEVEL_WIDTH]) begin
            w_down_level = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_level <= LEVEL_RST;
            r_step  <= 1'b0;
            r_dir   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_step <= w_up | w_down;
            r_err  <= w_both;
            if (w_up) begin
                r_dir   <= 1'b1;
                r_level <= w_up_level;
            end else if (w_down) begin
                r_dir   <= 1'b0;
                r_level <= w_down_level;
            end
        end
    end

    assign bus.level = r_level;
    assign bus.step  = r_step;
    assign bus.dir   = r_dir;
    assign bus.err   = r_err;
endmodule

// File: doc/encoder_level.md
# encoder_level

Converts a mechanical quadrature rotary encoder into a registered LEVEL_WIDTH-bit level that drives the `level` input of the PWM stage. It synchronises and debounces the two raw encoder channels, decodes Gray-code transitions (x4), and applies a saturating or wrapping up/down step to the level register. There is one instance per colour channel, directly upstream of each `pwm`.

## Interface
- LEVEL_WIDTH, 8: width of `level`; matches the downstream PWM.
- DEBOUNCE_CYCLES, 8: number of consecutive cycles a synchronised channel must differ from its debounced value before that value flips. Legal range 1..255.
- STEP, 1: amount added or subtracted per valid transition. Legal range 1..2^LEVEL_WIDTH-1.
- WRAP, 1'b0: 0 = saturate at 0 and 2^LEVEL_WIDTH-1; 1 = modular arithmetic.
- RESET_LEVEL, 0: value loaded into `level` on reset.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enc_a  input  1  raw encoder channel A; asynchronous, may bounce.
- enc_b  input  1  raw encoder channel B; asynchronous, may bounce.
- level  output  LEVEL_WIDTH  registered level, fed to `pwm.level`.
- step  output  1  one-cycle pulse for each valid Gray transition, including transitions absorbed by saturation.
- dir  output  1  direction of the last valid transition (1 = up). Held between steps.
- err  output  1  one-cycle pulse when both debounced channels change in the same cycle.

## Operation
- **Synchroniser:** two flops per channel. Reset value is 0.
- **Debouncer (per channel):** registers are `stable` (reset 0) and a counter of width clog2(DEBOUNCE_CYCLES+1) (reset 0).
  - When sync == stable, the counter clears to 0.
  - Otherwise the counter increments. When the incremented value would equal DEBOUNCE_CYCLES, `stable` takes the sync value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches `stable`.
- **Decoder:** `prev` = {stable_a, stable_b} registered one cycle, reset 00. Each cycle, `prev` is compared with the current {stable_a, stable_b}:
  - Up sequence: 00→10→11→01→00.
  - Down sequence: 00→01→11→10→00.
  - No change: idle. No outputs.
  - One-bit change along the up sequence: step=1, dir=1, level increases.
  - One-bit change along the down sequence: step=1, dir=0, level decreases.
  - Both bits change: err=1. Level and dir are unchanged and there is no step.
- **Level arithmetic:** computed in LEVEL_WIDTH+1 bits.
  - WRAP=0, up: if level+STEP > 2^LEVEL_WIDTH-1, level becomes 2^LEVEL_WIDTH-1.
  - WRAP=0, down: if level < STEP, level becomes 0.
  - WRAP=1: result is taken modulo 2^LEVEL_WIDTH.
- **Reset values:** level=RESET_LEVEL, step=0, dir=0, err=0. All internal state is 0.
- **Reset mid-operation:** reset overrides everything on the same edge. Pending debounce counts are discarded.
- **Encoder resting at 11 after reset:** both channels debounce from 00 to 11. If they flip in the same cycle, err pulses once and the level stays at RESET_LEVEL. This is intended, not a failure.

## Timing
- Let edge k be the first clk edge at which sync flop 1 samples a new stable raw value.
  - Sync flop 2 outputs the new value after edge k+1.
  - `stable` flips on edge k+1+DEBOUNCE_CYCLES.
  - `level`, `step`, `dir` and `err` update on edge k+2+DEBOUNCE_CYCLES.
- Total latency from raw input to level is DEBOUNCE_CYCLES+2 cycles.
- step and err are high for exactly one cycle per event and are never high together.
- `level` changes only in the cycle in which `step` is asserted. Under saturation, step asserts but level holds.
- Transitions closer together than DEBOUNCE_CYCLES+1 cycles on the same channel are not guaranteed to be counted.
- Maximum throughput is one step per cycle when the A and B edges are staggered.

## Test plan
1. **Reset idle.** Assert reset for 3 cycles, hold enc_a=enc_b=0 for 100 cycles (RESET_LEVEL=0) → level=0 and step, dir, err = 0 throughout.
2. **Up count with latency check.** Apply 00→10→11→01→00 with each state held 20 cycles (DEBOUNCE_CYCLES=8, STEP=1) → four step pulses with dir=1, level=4. The first step occurs exactly 10 cycles after enc_a rises, counted from edge k.
3. **Saturation.** From level=0, apply one down sequence (WRAP=0) → four step pulses with dir=0, level stays 0. Then preload to 254 with STEP=1 and apply 4 up transitions → level ends at 255.
4. **Wrap.** WRAP=1, level=255, one up transition → level=0. Then one down transition → level=255.
5. **Glitch and simultaneous change.**
   - A 5-cycle pulse on enc_a → no step and level unchanged.
   - enc_a and enc_b toggled on the same cycle, from 00 to 11 → one err pulse, no step, level unchanged.
6. **Reset mid-debounce.** Raise enc_a and assert reset 4 cycles later, held 1 cycle, then release → level=RESET_LEVEL. enc_a still high produces its step DEBOUNCE_CYCLES+2 cycles after reset release, with no earlier step.
